line_mem_responder: RTL

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/line_mem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/line_mem_responder.sv
// Cache-line memory responder: stores 2^IDX_W 128-bit lines and answers one read or write
// request at a time with a fixed LATENCY-cycle completion pulse.
module line_mem_responder #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned LATENCY = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [127:0]      mem_wdata,
  output logic [127:0]      mem_rdata,
  output logic              mem_ready,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              conflict_err
);

  localparam int unsigned Lines   = 1 << IDX_W;
  localparam logic [7:0]  LoadVal = 8'(LATENCY - 2);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [127:0]     wdata_q, wdata_d;
  logic             is_wr_q, is_wr_d;
  logic             conflict_q, conflict_d;
  logic [127:0]     rdata_q, rdata_d;
  logic [15:0]      rd_count_q, rd_count_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic             enter_resp;

  logic [127:0]     mem_q [Lines];

  // Upper address bits only alias the index.
  logic             unused_addr;
  assign unused_addr = ^mem_addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    conflict_d = conflict_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          state_d = StBusy;
          cnt_d   = LoadVal;
          idx_d   = mem_addr[IDX_W-1:0];
          wdata_d = mem_wdata;
          // A simultaneous read and write degrades to a write.
          is_wr_d = mem_write;
          if (mem_read && mem_write) begin
            conflict_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 8'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (enter_resp) begin
      if (is_wr_q) begin
        if (wr_count_q != 16'hFFFF) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end else begin
        rdata_d = mem_q[idx_q];
        if (rd_count_q != 16'hFFFF) begin
          rd_count_d = rd_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Storage is never reset; a write lands on the edge that leaves the response cycle.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StResp && is_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign mem_ready    = (state_q == StResp);
  assign mem_rdata    = rdata_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;
  assign conflict_err = conflict_q;

endmodule
